// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter with packet-atomic grants onto one valid/ready channel.
// Latency: 1 cycle from request to grant; zero-latency combinational datapath while granted.
// Backpressure: out_ready feeds only the granted requester. Optional stall timeout: MUX2_ARB_TIMEOUT_EN.
module mux2_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    input  logic             in2_valid,
    output logic             in2_ready,
    input  logic [WIDTH-1:0] in2_data,
    input  logic             in2_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             sel,
    output logic             busy
`ifdef MUX2_ARB_TIMEOUT_EN
    ,
    output logic             timeout_pulse
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT1, S_GRANT2} state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_sel;
    logic   r_last_served;   // 0 = in1, 1 = in2
    logic   w_xfer;
    logic   w_release;
    logic   w_timeout;

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("mux2_arbiter: TIMEOUT must be within 2..65535");
    end

    assign w_xfer    = out_valid & out_ready;
    assign w_release = (w_xfer & out_last) | w_timeout;

`ifdef MUX2_ARB_TIMEOUT_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = ((r_state == S_GRANT1) && !in1_valid) ||
                     ((r_state == S_GRANT2) && !in2_valid);
    assign w_timeout     = w_stall && (r_stall_cnt == 16'(TIMEOUT - 1));
    assign timeout_pulse = w_timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!w_stall || (w_next_state != r_state)) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_sel         <= 1'b0;
            r_last_served <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == S_GRANT1) begin
                r_sel <= 1'b0;
            end else if (w_next_state == S_GRANT2) begin
                r_sel <= 1'b1;
            end
            if (w_release) begin
                r_last_served <= (r_state == S_GRANT2);
            end
        end
    end

    // The beat being accepted at release carries the only valid we can see, so it cannot
    // announce a follow-on packet: with no rival waiting, the requester re-arbitrates via IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in1_valid && in2_valid) begin
                    w_next_state = r_last_served ? S_GRANT1 : S_GRANT2;
                end else if (in1_valid) begin
                    w_next_state = S_GRANT1;
                end else if (in2_valid) begin
                    w_next_state = S_GRANT2;
                end
            end
            S_GRANT1: if (w_release) w_next_state = in2_valid ? S_GRANT2 : S_IDLE;
            S_GRANT2: if (w_release) w_next_state = in1_valid ? S_GRANT1 : S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        in1_ready = 1'b0;
        in2_ready = 1'b0;
        case (r_state)
            S_GRANT1: begin
                out_valid = in1_valid;
                out_data  = in1_data;
                out_last  = in1_last;
                in1_ready = out_ready;
            end
            S_GRANT2: begin
                out_valid = in2_valid;
                out_data  = in2_data;
                out_last  = in2_last;
                in2_ready = out_ready;
            end
            default: ;
        endcase
    end

    assign sel  = r_sel;
    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: directed scenarios plus a randomized packet scoreboard.
module tb_mux2_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in1_valid, in1_ready, in1_last;
    logic [7:0] in1_data;
    logic       in2_valid, in2_ready, in2_last;
    logic [7:0] in2_data;
    logic       out_valid, out_ready, out_last;
    logic [7:0] out_data;
    logic       sel, busy;
`ifdef MUX2_ARB_TIMEOUT_EN
    logic       timeout_pulse;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mux2_arbiter #(.WIDTH(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data), .in1_last(in1_last),
        .in2_valid(in2_valid), .in2_ready(in2_ready), .in2_data(in2_data), .in2_last(in2_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .sel(sel), .busy(busy)
`ifdef MUX2_ARB_TIMEOUT_EN
        , .timeout_pulse(timeout_pulse)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        in1_valid = 0; in1_data = 0; in1_last = 0;
        in2_valid = 0; in2_data = 0; in2_last = 0;
        out_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        repeat (2) step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        repeat (2) step();
        smp();
        n_tests++; if (sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %0b want 0", sel); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_tests++; if ({in1_ready, in2_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_readys: got %b want 00", {in1_ready, in2_ready}); end
        n_tests++; if ({out_last, out_data} !== 9'h000) begin n_fail++; $display("FAIL reset_out_data: got %0h want 0", {out_last, out_data}); end
        step();
        rst_n = 1;
    endtask

    task automatic test_single();
        in1_valid = 1; in1_data = 8'h11; in1_last = 0; out_ready = 1;
        smp();
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got valid=%0b busy=%0b want 0 0", out_valid, busy); end
        step(); smp();
        n_tests++; if (busy !== 1'b1 || sel !== 1'b0 || in1_ready !== 1'b1) begin n_fail++; $display("FAIL single_grant: got busy=%0b sel=%0b rdy=%0b want 1 0 1", busy, sel, in1_ready); end
        n_tests++; if (out_data !== 8'h11) begin n_fail++; $display("FAIL single_beat0: got %0h want 11", out_data); end
        step(); in1_data = 8'h22; smp();
        n_tests++; if (out_data !== 8'h22) begin n_fail++; $display("FAIL single_beat1: got %0h want 22", out_data); end
        step(); in1_data = 8'h33; in1_last = 1; smp();
        n_tests++; if (out_data !== 8'h33 || out_last !== 1'b1) begin n_fail++; $display("FAIL single_beat2: got %0h last=%0b want 33 1", out_data, out_last); end
        step(); in1_valid = 0; in1_last = 0; smp();
        n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL single_release: got busy=%0b valid=%0b want 0 0", busy, out_valid); end
    endtask

    task automatic test_tie();
        do_reset();
        in1_valid = 1; in1_data = 8'hA1; in1_last = 1;
        in2_valid = 1; in2_data = 8'hB2; in2_last = 1;
        out_ready = 1;
        smp();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL tie_idle: got %0b want 0", out_valid); end
        step(); smp();
        n_tests++; if (sel !== 1'b0 || out_data !== 8'hA1 || in2_ready !== 1'b0) begin n_fail++; $display("FAIL tie_first: got sel=%0b data=%0h r2=%0b want 0 a1 0", sel, out_data, in2_ready); end
        step(); in1_valid = 0; smp();
        n_tests++; if (sel !== 1'b1 || out_data !== 8'hB2 || in2_ready !== 1'b1 || in1_ready !== 1'b0) begin n_fail++; $display("FAIL tie_second: got sel=%0b data=%0h r1=%0b r2=%0b want 1 b2 0 1", sel, out_data, in1_ready, in2_ready); end
        step(); in2_valid = 0; smp();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tie_done: got busy=%0b want 0", busy); end
    endtask

    task automatic test_atomic();
        in2_valid = 1; in2_data = 8'hC0; in2_last = 0; out_ready = 1;
        smp();
        step(); smp();
        n_tests++; if (sel !== 1'b1 || out_data !== 8'hC0) begin n_fail++; $display("FAIL atomic_grant2: got sel=%0b data=%0h want 1 c0", sel, out_data); end
        step(); in2_data = 8'hC1; in1_valid = 1; in1_data = 8'h55; in1_last = 1; smp();
        n_tests++; if (out_data !== 8'hC1 || in1_ready !== 1'b0 || in2_ready !== 1'b1) begin n_fail++; $display("FAIL atomic_mid: got data=%0h r1=%0b r2=%0b want c1 0 1", out_data, in1_ready, in2_ready); end
        step(); in2_data = 8'hC2; in2_last = 1; out_ready = 0; smp();
        n_tests++; if (out_data !== 8'hC2 || out_valid !== 1'b1 || {in1_ready, in2_ready} !== 2'b00) begin n_fail++; $display("FAIL atomic_stall: got data=%0h v=%0b rdys=%b want c2 1 00", out_data, out_valid, {in1_ready, in2_ready}); end
        step(); out_ready = 1; smp();
        n_tests++; if (out_data !== 8'hC2 || out_last !== 1'b1 || sel !== 1'b1 || in1_ready !== 1'b0) begin n_fail++; $display("FAIL atomic_held: got data=%0h last=%0b sel=%0b r1=%0b want c2 1 1 0", out_data, out_last, sel, in1_ready); end
        step(); in2_valid = 0; in2_last = 0; out_ready = 0; smp();
        n_tests++; if (sel !== 1'b0 || out_data !== 8'h55 || in1_ready !== 1'b0) begin n_fail++; $display("FAIL atomic_switch: got sel=%0b data=%0h r1=%0b want 0 55 0", sel, out_data, in1_ready); end
        step(); out_ready = 1; smp();
        n_tests++; if (in1_ready !== 1'b1) begin n_fail++; $display("FAIL atomic_in1_ready: got %0b want 1", in1_ready); end
        step(); in1_valid = 0; in1_last = 0; smp();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL atomic_done: got busy=%0b want 0", busy); end
    endtask

    task automatic test_fairness();
        logic [7:0] d1, d2;
        int want, pk, cyc;
        do_reset();
        d1 = 8'h10; d2 = 8'h80; want = 1; pk = 0; cyc = 0;
        in1_valid = 1; in1_last = 1; in2_valid = 1; in2_last = 1; out_ready = 1;
        while (pk < 8 && cyc < 40) begin
            in1_data = d1; in2_data = d2;
            smp();
            if (out_valid && out_ready) begin
                n_tests++; if ((sel ? 2 : 1) != want) begin n_fail++; $display("FAIL fair_order: packet %0d got requester %0d want %0d", pk, sel ? 2 : 1, want); end
                n_tests++; if (out_data !== (want == 1 ? d1 : d2)) begin n_fail++; $display("FAIL fair_data: packet %0d got %0h want %0h", pk, out_data, want == 1 ? d1 : d2); end
                if (in1_ready) d1 = d1 + 8'd1;
                else if (in2_ready) d2 = d2 + 8'd1;
                want = 3 - want;
                pk++;
            end
            step();
            cyc++;
        end
        n_tests++; if (pk != 8) begin n_fail++; $display("FAIL fair_count: got %0d packets want 8", pk); end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [8:0] q1[$];
        logic [8:0] q2[$];
        int own, cyc, len, s;
        logic t1, t2, pop1, pop2;
        do_reset();
        for (int p = 0; p < 12; p++) begin
            len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++) q1.push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
            len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++) q2.push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
        end
        own = 0; cyc = 0;
        while ((q1.size() > 0 || q2.size() > 0 || in1_valid || in2_valid) && cyc < 3000) begin
            pop1 = 0; pop2 = 0;
            if (!in1_valid && q1.size() > 0 && $urandom_range(3) != 0) begin in1_valid = 1; {in1_last, in1_data} = q1[0]; end
            if (!in2_valid && q2.size() > 0 && $urandom_range(3) != 0) begin in2_valid = 1; {in2_last, in2_data} = q2[0]; end
            out_ready = ($urandom_range(3) != 0);
            smp();
            t1 = in1_valid && in1_ready;
            t2 = in2_valid && in2_ready;
            n_tests++; if ((in1_ready && in2_ready) || ((out_valid && out_ready) != (t1 || t2))) begin n_fail++; $display("FAIL rand_handshake: cycle %0d r1=%0b r2=%0b ov=%0b or=%0b", cyc, in1_ready, in2_ready, out_valid, out_ready); end
            if (t1 || t2) begin
                s = t1 ? 1 : 2;
                n_tests++; if ({out_last, out_data} !== (t1 ? q1[0] : q2[0])) begin n_fail++; $display("FAIL rand_beat: cycle %0d got %0h want %0h", cyc, {out_last, out_data}, t1 ? q1[0] : q2[0]); end
                n_tests++; if (own != 0 && own != s) begin n_fail++; $display("FAIL rand_atomic: cycle %0d got requester %0d want %0d", cyc, s, own); end
                own = out_last ? 0 : s;
                if (t1) begin void'(q1.pop_front()); pop1 = 1; end
                else begin void'(q2.pop_front()); pop2 = 1; end
            end
            step();
            if (pop1) in1_valid = 0;
            if (pop2) in2_valid = 0;
            cyc++;
        end
        n_tests++; if (q1.size() != 0 || q2.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d/%0d beats left want 0/0", q1.size(), q2.size()); end
        clear_inputs();
    endtask

`ifdef MUX2_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        in1_valid = 1; in1_data = 8'h77; in1_last = 0; out_ready = 1;
        smp();
        n_tests++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL to_idle_pulse: got %0b want 0", timeout_pulse); end
        step(); smp();
        n_tests++; if (sel !== 1'b0 || out_data !== 8'h77) begin n_fail++; $display("FAIL to_grant1: got sel=%0b data=%0h want 0 77", sel, out_data); end
        step(); in1_valid = 0; in2_valid = 1; in2_data = 8'h88; in2_last = 1;
        for (int k = 1; k <= 4; k++) begin
            smp();
            n_tests++; if (timeout_pulse !== (k == 4)) begin n_fail++; $display("FAIL to_pulse: stall cycle %0d got %0b want %0b", k, timeout_pulse, k == 4); end
            n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL to_no_last: stall cycle %0d got %0b want 0", k, out_last); end
            step();
        end
        smp();
        n_tests++; if (sel !== 1'b1 || out_data !== 8'h88 || timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL to_grant2: got sel=%0b data=%0h pulse=%0b want 1 88 0", sel, out_data, timeout_pulse); end
        step();
        clear_inputs();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_atomic();
        test_fairness();
        test_random();
`ifdef MUX2_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
